// File: rtl/ball_motion.sv
// Breakout ball kinematics: tick-paced movement, crash reflection with clamping,
// and the serve/miss/game-over sequence with a lives counter. Optional BALL_SPEEDUP_EN.
module ball_motion #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BALL_R     = 10,
    parameter int STEP       = 1,
    parameter int TICK_DIV   = 200000,
    parameter int START_X    = 320,
    parameter int START_Y    = 400,
    parameter int LIVES      = 3,
    parameter int HOLD_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] iCrash,
    input  logic       iStart,
    output logic [9:0] oBall_x,
    output logic [9:0] oBall_y,
    output logic       oMove,
    output logic [1:0] oState,
    output logic [1:0] oLives,
    output logic       oGame_over
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [9:0]        POS_LO     = 10'(BALL_R);
    localparam logic [9:0]        X_HI       = 10'(H_RES - BALL_R);
    localparam logic [9:0]        Y_HI       = 10'(V_RES - BALL_R);
    localparam logic [9:0]        SERVE_X    = 10'(START_X);
    localparam logic [9:0]        SERVE_Y    = 10'(START_Y);
    localparam logic [2:0]        STEP_INIT  = 3'(STEP);
    localparam logic [1:0]        LIVES_INIT = 2'(LIVES);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        READY = 2'd0,
        RUN   = 2'd1,
        MISS  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [HOLD_W-1:0]  hold_reg;
    logic [9:0]         x_reg;
    logic [9:0]         y_reg;
    logic               dx_reg;
    logic               dy_reg;
    logic [1:0]         lives_reg;
    logic               move_reg;
    logic               game_over_reg;

    logic               tick;
    logic               crash_left;
    logic               crash_right;
    logic               crash_up;
    logic               crash_down;
    logic               dx_next;
    logic               dy_next;
    logic               miss_hit;
    logic [9:0]         x_next;
    logic [9:0]         y_next;
    logic [2:0]         step;

    // Move one axis by stp in 11 bits and clamp to [POS_LO, hi] so it never wraps.
    function automatic logic [9:0] advance(
        input logic [9:0] pos,
        input logic       dir,
        input logic [2:0] stp,
        input logic [9:0] hi
    );
        logic [10:0] sum;
        if (dir) begin
            sum = {1'b0, pos} + {8'd0, stp};
            if (sum > {1'b0, hi}) begin
                sum = {1'b0, hi};
            end
        end else begin
            sum = {1'b0, pos} - {8'd0, stp};
            if (sum[10] || (sum < {1'b0, POS_LO})) begin
                sum = {1'b0, POS_LO};
            end
        end
        return sum[9:0];
    endfunction

    assign tick        = (cnt_reg == CNT_LAST);
    assign crash_left  = iCrash[3];
    assign crash_right = iCrash[2];
    assign crash_up    = iCrash[1];
    assign crash_down  = iCrash[0];

    always_comb begin
        dx_next = dx_reg;
        dy_next = dy_reg;
        if (crash_left && !crash_right) begin
            dx_next = 1'b1;
        end else if (crash_right && !crash_left) begin
            dx_next = 1'b0;
        end
        if (crash_up && !crash_down) begin
            dy_next = 1'b1;
        end else if (crash_down && !crash_up) begin
            dy_next = 1'b0;
        end
        x_next   = advance(x_reg, dx_next, step, X_HI);
        y_next   = advance(y_reg, dy_next, step, Y_HI);
        miss_hit = (y_reg >= Y_HI) && dy_reg;
    end

`ifdef BALL_SPEEDUP_EN
    logic [3:0] hit_reg;
    logic [2:0] step_reg;
    logic       run_tick;
    logic       enter_ready;

    assign run_tick    = tick && (state_reg == RUN);
    assign enter_ready = tick && (((state_reg == MISS) && (hold_reg == HOLD_LAST) && (lives_reg != 2'd1))
                               || ((state_reg == OVER) && iStart));

    // Every 16th crash tick bumps the speed, capped at 4 px/tick.
    always_ff @(posedge clk) begin
        if (rst || enter_ready) begin
            hit_reg  <= 4'd0;
            step_reg <= STEP_INIT;
        end else if (run_tick && (iCrash != 4'd0)) begin
            hit_reg <= hit_reg + 4'd1;
            if ((hit_reg == 4'd15) && (step_reg < 3'd4)) begin
                step_reg <= step_reg + 3'd1;
            end
        end
    end

    assign step = step_reg;
`else
    assign step = STEP_INIT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= READY;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            x_reg         <= SERVE_X;
            y_reg         <= SERVE_Y;
            dx_reg        <= 1'b1;
            dy_reg        <= 1'b0;
            lives_reg     <= LIVES_INIT;
            move_reg      <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            move_reg <= 1'b0;
            cnt_reg  <= tick ? '0 : cnt_reg + 1'b1;
            if (tick) begin
                case (state_reg)
                    READY: begin
                        if (iStart) begin
                            state_reg <= RUN;
                        end
                    end
                    RUN: begin
                        // A ball already on the floor and still falling is lost; it does not move.
                        if (miss_hit) begin
                            state_reg <= MISS;
                        end else begin
                            dx_reg   <= dx_next;
                            dy_reg   <= dy_next;
                            x_reg    <= x_next;
                            y_reg    <= y_next;
                            move_reg <= 1'b1;
                        end
                    end
                    MISS: begin
                        if (hold_reg == HOLD_LAST) begin
                            hold_reg  <= '0;
                            lives_reg <= lives_reg - 2'd1;
                            x_reg     <= SERVE_X;
                            y_reg     <= SERVE_Y;
                            if (lives_reg == 2'd1) begin
                                state_reg     <= OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                state_reg <= READY;
                                dx_reg    <= 1'b1;
                                dy_reg    <= 1'b0;
                            end
                        end else begin
                            hold_reg <= hold_reg + 1'b1;
                        end
                    end
                    OVER: begin
                        if (iStart) begin
                            state_reg     <= READY;
                            lives_reg     <= LIVES_INIT;
                            game_over_reg <= 1'b0;
                            x_reg         <= SERVE_X;
                            y_reg         <= SERVE_Y;
                            dx_reg        <= 1'b1;
                            dy_reg        <= 1'b0;
                        end
                    end
                    default: state_reg <= READY;
                endcase
            end
        end
    end

    assign oBall_x    = x_reg;
    assign oBall_y    = y_reg;
    assign oMove      = move_reg;
    assign oState     = state_reg;
    assign oLives     = lives_reg;
    assign oGame_over = game_over_reg;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus random stimulus,
// all compared against an integer-arithmetic model of the game rules.
module tb_ball_motion;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int BALL_R     = 10;
    localparam int STEP       = 1;
    localparam int TICK_DIV   = 4;
    localparam int START_X    = 320;
    localparam int START_Y    = 400;
    localparam int LIVES      = 2;
    localparam int HOLD_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] iCrash = 4'd0;
    logic       iStart = 1'b0;
    logic [9:0] oBall_x;
    logic [9:0] oBall_y;
    logic       oMove;
    logic [1:0] oState;
    logic [1:0] oLives;
    logic       oGame_over;

    int errors = 0;
    int checks = 0;

    // Model of the game: plain integers, updated from the rules once per clock.
    int m_x, m_y, m_dx, m_dy, m_state, m_lives, m_hold, m_cnt, m_step, m_hits;
    int m_move, m_go;
    int cyc = 0;

    ball_motion #(
        .H_RES(H_RES), .V_RES(V_RES), .BALL_R(BALL_R), .STEP(STEP),
        .TICK_DIV(TICK_DIV), .START_X(START_X), .START_Y(START_Y),
        .LIVES(LIVES), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .iCrash(iCrash), .iStart(iStart),
        .oBall_x(oBall_x), .oBall_y(oBall_y), .oMove(oMove),
        .oState(oState), .oLives(oLives), .oGame_over(oGame_over)
    );

    always #5 clk = ~clk;

    logic [25:0] dut_vec;
    assign dut_vec = {oState, oLives, oGame_over, oMove, oBall_x, oBall_y};

    function automatic logic [25:0] exp_vec();
        return {2'(m_state), 2'(m_lives), 1'(m_go), 1'(m_move), 10'(m_x), 10'(m_y)};
    endfunction

    task automatic serve();
        m_state = 0;
        m_x = START_X;
        m_y = START_Y;
        m_dx = 1;
        m_dy = 0;
        m_step = STEP;
        m_hits = 0;
    endtask

    task automatic model_reset();
        serve();
        m_cnt = 0;
        m_hold = 0;
        m_lives = LIVES;
        m_move = 0;
        m_go = 0;
    endtask

    // Advance the model with the inputs currently driven, then clock the DUT.
    task automatic step_cycle();
        bit tick;
        if (rst) begin
            model_reset();
        end else begin
            tick = (m_cnt == TICK_DIV - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            m_move = 0;
            if (tick) begin
                case (m_state)
                    0: if (iStart) m_state = 1;
                    1: begin
`ifdef BALL_SPEEDUP_EN
                        if (iCrash != 4'd0) begin
                            m_hits = (m_hits + 1) % 16;
                            if (m_hits == 0 && m_step < 4) m_step++;
                        end
`endif
                        if (m_y >= V_RES - BALL_R && m_dy == 1) begin
                            m_state = 2;
                        end else begin
                            if (iCrash[3] && !iCrash[2]) m_dx = 1;
                            else if (iCrash[2] && !iCrash[3]) m_dx = 0;
                            if (iCrash[1] && !iCrash[0]) m_dy = 1;
                            else if (iCrash[0] && !iCrash[1]) m_dy = 0;
                            m_x = m_dx ? m_x + m_step : m_x - m_step;
                            m_y = m_dy ? m_y + m_step : m_y - m_step;
                            if (m_x > H_RES - BALL_R) m_x = H_RES - BALL_R;
                            if (m_x < BALL_R) m_x = BALL_R;
                            if (m_y > V_RES - BALL_R) m_y = V_RES - BALL_R;
                            if (m_y < BALL_R) m_y = BALL_R;
                            m_move = 1;
                        end
                    end
                    2: begin
                        m_hold++;
                        if (m_hold == HOLD_TICKS) begin
                            m_hold = 0;
                            m_lives--;
                            if (m_lives == 0) begin
                                m_state = 3;
                                m_go = 1;
                                m_x = START_X;
                                m_y = START_Y;
                            end else begin
                                serve();
                            end
                        end
                    end
                    default: if (iStart) begin
                        m_lives = LIVES;
                        m_go = 0;
                        serve();
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iStart = 1'b0;
        iCrash = 4'd0;
        step_cycle();
        step_cycle();
        checks++;
        if (dut_vec !== 26'({2'd0, 2'(LIVES), 1'b0, 1'b0, 10'(START_X), 10'(START_Y)})) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", dut_vec, exp_vec());
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            checks++;
            if (dut_vec !== exp_vec() || oMove !== 1'b0 || oState !== 2'd0) begin
                errors++;
                $display("FAIL idle_ready cycle %0d: got %h required %h", i, dut_vec, exp_vec());
            end
        end
        $display("reset: READY held at (%0d,%0d) for 20 cycles", oBall_x, oBall_y);
    endtask

    task automatic test_serve();
        int moves = 0;
        int last_move = 0;
        int n = 0;
        iStart = 1'b1;
        iCrash = 4'd0;
        while (moves < 3 && n < 100) begin
            step_cycle();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL serve_track: got %h required %h", dut_vec, exp_vec());
            end
            if (oMove === 1'b1) begin
                moves++;
                checks++;
                if (moves == 1 && (oBall_x !== 10'd321 || oBall_y !== 10'd399)) begin
                    errors++;
                    $display("FAIL serve_first_move: got (%0d,%0d) required (321,399)", oBall_x, oBall_y);
                end else if (moves == 2 && (oBall_x !== 10'd322 || oBall_y !== 10'd398)) begin
                    errors++;
                    $display("FAIL serve_second_move: got (%0d,%0d) required (322,398)", oBall_x, oBall_y);
                end else if (moves > 1 && cyc - last_move != TICK_DIV) begin
                    errors++;
                    $display("FAIL serve_move_spacing: got %0d cycles required %0d", cyc - last_move, TICK_DIV);
                end
                last_move = cyc;
                $display("serve: move %0d to (%0d,%0d)", moves, oBall_x, oBall_y);
            end
        end
        checks++;
        if (moves < 3) begin
            errors++;
            $display("FAIL serve_timeout: got %0d moves required 3", moves);
        end
    endtask

    // Run with no crash until the next tick cycle, then apply crash on that tick.
    task automatic crash_on_tick(input logic [3:0] crash, input string tag);
        int n = 0;
        iCrash = 4'd0;
        while (m_cnt != TICK_DIV - 1 && n < 10) begin
            step_cycle();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL %s_pre: got %h required %h", tag, dut_vec, exp_vec());
            end
        end
        iCrash = crash;
        step_cycle();
        iCrash = 4'd0;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL %s_tick: got %h required %h", tag, dut_vec, exp_vec());
        end
    endtask

    task automatic test_reflect();
        int n = 0;
        while (!(m_cnt == TICK_DIV - 1 && m_x == 330 && m_y == 390) && n < 200) begin
            step_cycle();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reflect_approach: got %h required %h", dut_vec, exp_vec());
            end
        end
        crash_on_tick(4'b0100, "reflect_right");
        checks++;
        if (oBall_x !== 10'd329 || oBall_y !== 10'd389 || oMove !== 1'b1) begin
            errors++;
            $display("FAIL reflect_right_pos: got (%0d,%0d) mv=%0b required (329,389) mv=1", oBall_x, oBall_y, oMove);
        end
        $display("reflect: right crash at (330,390) -> (%0d,%0d)", oBall_x, oBall_y);
        crash_on_tick(4'b1100, "reflect_both");
        checks++;
        if (oBall_x !== 10'd328 || oBall_y !== 10'd388) begin
            errors++;
            $display("FAIL reflect_both_pos: got (%0d,%0d) required (328,388)", oBall_x, oBall_y);
        end
        $display("reflect: left+right crash keeps dx -> (%0d,%0d)", oBall_x, oBall_y);
    endtask

    task automatic run_until_state(input int target, input int limit, input string tag);
        int n = 0;
        while (m_state != target && n < limit) begin
            step_cycle();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL %s: got %h required %h", tag, dut_vec, exp_vec());
            end
        end
        checks++;
        if (m_state != target) begin
            errors++;
            $display("FAIL %s_timeout: got state %0d required %0d", tag, oState, target);
        end
    endtask

    task automatic test_miss();
        crash_on_tick(4'b0010, "miss_turn_down");
        run_until_state(2, 2000, "miss_fall");
        checks++;
        if (oState !== 2'd2 || oBall_y !== 10'd470) begin
            errors++;
            $display("FAIL miss_enter: got st=%0d y=%0d required st=2 y=470", oState, oBall_y);
        end
        $display("miss: lost ball at (%0d,%0d) lives=%0d", oBall_x, oBall_y, oLives);
        run_until_state(0, 50, "miss_hold");
        checks++;
        if (oLives !== 2'd1 || oState !== 2'd0 || oBall_x !== 10'd320 || oBall_y !== 10'd400) begin
            errors++;
            $display("FAIL miss_reserve: got lv=%0d st=%0d (%0d,%0d) required lv=1 st=0 (320,400)",
                     oLives, oState, oBall_x, oBall_y);
        end
        $display("miss: re-serve lives=%0d", oLives);
        run_until_state(1, 20, "miss_restart");
        crash_on_tick(4'b0010, "miss2_turn_down");
        run_until_state(3, 4000, "miss2_fall");
        checks++;
        if (oLives !== 2'd0 || oState !== 2'd3 || oGame_over !== 1'b1) begin
            errors++;
            $display("FAIL game_over: got lv=%0d st=%0d go=%0b required lv=0 st=3 go=1", oLives, oState, oGame_over);
        end
        $display("miss: game over lives=%0d", oLives);
        run_until_state(0, 20, "over_restart");
        checks++;
        if (oLives !== 2'd2 || oState !== 2'd0 || oGame_over !== 1'b0) begin
            errors++;
            $display("FAIL over_restart_vals: got lv=%0d st=%0d go=%0b required lv=2 st=0 go=0", oLives, oState, oGame_over);
        end
        $display("over: restarted lives=%0d", oLives);
    endtask

    task automatic test_clamp();
        int n = 0;
        int prev_x = 0;
        run_until_state(1, 20, "clamp_start");
        crash_on_tick(4'b0100, "clamp_turn_left");
        while (m_x != BALL_R && n < 3000) begin
            prev_x = oBall_x;
            step_cycle();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL clamp_travel: got %h required %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (oBall_x !== 10'd10 || prev_x != 11) begin
            errors++;
            $display("FAIL clamp_land: got x=%0d from %0d required x=10 from 11", oBall_x, prev_x);
        end
        crash_on_tick(4'b0000, "clamp_hold");
        checks++;
        if (oBall_x !== 10'd10) begin
            errors++;
            $display("FAIL clamp_stay: got x=%0d required 10", oBall_x);
        end
        $display("clamp: ball at (%0d,%0d) after left wall", oBall_x, oBall_y);
    endtask

    task automatic test_reset_mid();
        crash_on_tick(4'b0010, "rstmid_turn_down");
        run_until_state(2, 4000, "rstmid_fall");
        rst = 1'b1;
        step_cycle();
        checks++;
        if (dut_vec !== 26'({2'd0, 2'(LIVES), 1'b0, 1'b0, 10'(START_X), 10'(START_Y)})) begin
            errors++;
            $display("FAIL reset_mid_miss: got %h required %h", dut_vec, exp_vec());
        end
        rst = 1'b0;
        $display("reset: abort from MISS -> st=%0d (%0d,%0d)", oState, oBall_x, oBall_y);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            iStart = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                iCrash = 4'($urandom_range(0, 15));
            end else begin
                iCrash = {m_x <= BALL_R, m_x >= H_RES - BALL_R, m_y <= BALL_R, $urandom_range(0, 40) == 0};
            end
            step_cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random cycle %0d: got %h required %h", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b0;
        iCrash = 4'd0;
        $display("random: 3000 cycles, final st=%0d lives=%0d", oState, oLives);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve();
        test_reflect();
        test_miss();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
